// File: rtl/video_timing_pkg.sv
// Shared constants for the output-side video timing path.
package video_timing_pkg;

  // CPS2 source image geometry and line-buffer depth
  localparam int unsigned CPS2_H_ACTIVE = 384;
  localparam int unsigned CPS2_V_ACTIVE = 224;
  localparam int unsigned LBUF_SLOTS    = 40;

  // Sync polarity: pulses are active-low
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  // Counter and comparison widths
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned CMP_W   = 12;
  localparam int unsigned HLBUF_W = 9;
  localparam int unsigned VLBUF_W = 6;
  localparam int unsigned SCTR_W  = 3;

  // True when pos lies in [start, start+len)
  function automatic logic in_window(input logic [CMP_W-1:0] pos,
                                     input int unsigned start,
                                     input int unsigned len);
    return (pos >= CMP_W'(start)) && (pos < CMP_W'(start + len));
  endfunction

endpackage

// File: rtl/scale_ctr.sv
// Sub-counter wrapping at SCALE-1 that steps a main counter on each wrap;
// the main counter either holds or wraps to 0 at MAIN_MAX.
module scale_ctr #(
  parameter int unsigned SCALE    = 3,
  parameter int unsigned SUB_W    = 3,
  parameter int unsigned MAIN_W   = 9,
  parameter int unsigned MAIN_MAX = 383,
  parameter bit          WRAP     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [SUB_W-1:0]  sub,
  output logic [MAIN_W-1:0] main
);

  // Clear has priority over advance; counts only while advance is high
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sub  <= '0;
      main <= '0;
    end else if (advance) begin
      if (sub == SUB_W'(SCALE - 1)) begin
        sub <= '0;
        if (main == MAIN_W'(MAIN_MAX)) begin
          main <= WRAP ? '0 : main;
        end else begin
          main <= main + MAIN_W'(1);
        end
      end else begin
        sub <= sub + SUB_W'(1);
      end
    end
  end

endmodule

// File: rtl/ext_timing_gen.sv
// Output pixel-clock timing generator: counters, sync/DE, line-buffer read
// address and sub-pixel counters, all registered and describing one pixel.
module ext_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL      = 1650,
  parameter int unsigned H_SYNCLEN    = 40,
  parameter int unsigned H_BACKPORCH  = 220,
  parameter int unsigned H_ACTIVE     = 1280,
  parameter int unsigned V_TOTAL      = 750,
  parameter int unsigned V_SYNCLEN    = 5,
  parameter int unsigned V_BACKPORCH  = 20,
  parameter int unsigned V_ACTIVE     = 720,
  parameter int unsigned H_SCALE      = 3,
  parameter int unsigned V_SCALE      = 3,
  parameter int unsigned H_IMG_OFFSET = 64,
  parameter int unsigned V_IMG_OFFSET = 24,
  parameter int unsigned V_LOCK_LINE  = 0
) (
  input  logic               PCLK_ext,
  input  logic               reset,
  input  logic               lock_en,
  input  logic               frame_sync,
  output logic [CNT_W-1:0]   hcnt_ext,
  output logic [CNT_W-1:0]   vcnt_ext,
  output logic [HLBUF_W-1:0] hcnt_ext_lbuf,
  output logic [VLBUF_W-1:0] vcnt_ext_lbuf,
  output logic [SCTR_W-1:0]  hctr_ext,
  output logic [SCTR_W-1:0]  vctr_ext,
  output logic               HSYNC_ext,
  output logic               VSYNC_ext,
  output logic               DE_ext
);

  localparam int unsigned H_AVS     = H_SYNCLEN + H_BACKPORCH;
  localparam int unsigned V_AVS     = V_SYNCLEN + V_BACKPORCH;
  localparam int unsigned H_IMG     = H_AVS + H_IMG_OFFSET;
  localparam int unsigned V_IMG     = V_AVS + V_IMG_OFFSET;
  localparam int unsigned H_IMG_LEN = CPS2_H_ACTIVE * H_SCALE;
  localparam int unsigned V_IMG_LEN = CPS2_V_ACTIVE * V_SCALE;

  localparam bit PARAMS_OK =
    (H_SCALE >= 1) && (H_SCALE <= 5) && (V_SCALE >= 1) && (V_SCALE <= 5) &&
    (H_AVS + H_ACTIVE <= H_TOTAL) && (V_AVS + V_ACTIVE <= V_TOTAL) &&
    (H_IMG_OFFSET + H_IMG_LEN <= H_ACTIVE) &&
    (V_IMG_OFFSET + V_IMG_LEN <= V_ACTIVE) &&
    (V_LOCK_LINE < V_TOTAL) &&
    (H_TOTAL <= (32'd1 << CNT_W)) && (V_TOTAL <= (32'd1 << CNT_W));

  // Elaboration-time guard on the timing parameters
  if (!PARAMS_OK) begin : g_param_check
    $error("ext_timing_gen: timing parameters out of range");
  end

  logic             lock_pending;
  logic             line_end_c;
  logic             lock_now_c;
  logic [CNT_W-1:0] h_nxt_c;
  logic [CNT_W-1:0] v_nxt_c;
  logic             h_clear_c;
  logic             v_clear_c;

  // Next pixel position; a pending or coincident lock replaces the line step
  always_comb begin
    line_end_c = (hcnt_ext == CNT_W'(H_TOTAL - 1));
    lock_now_c = lock_en && (lock_pending || frame_sync);
    h_nxt_c    = line_end_c ? '0 : hcnt_ext + CNT_W'(1);
    v_nxt_c    = vcnt_ext;
    if (line_end_c) begin
      if (lock_now_c) begin
        v_nxt_c = CNT_W'(V_LOCK_LINE);
      end else if (vcnt_ext == CNT_W'(V_TOTAL - 1)) begin
        v_nxt_c = '0;
      end else begin
        v_nxt_c = vcnt_ext + CNT_W'(1);
      end
    end
  end

  // Sub-pixel counters restart at the image origin and are held at 0 outside it
  always_comb begin
    h_clear_c = !in_window(CMP_W'(h_nxt_c), H_IMG, H_IMG_LEN) ||
                (CMP_W'(h_nxt_c) == CMP_W'(H_IMG));
    v_clear_c = line_end_c &&
                (!in_window(CMP_W'(v_nxt_c), V_IMG, V_IMG_LEN) ||
                 (CMP_W'(v_nxt_c) == CMP_W'(V_IMG)));
  end

  // Counters, sync/DE and lock-pending flag, all decoded from the next position
  always_ff @(posedge PCLK_ext) begin
    if (reset) begin
      hcnt_ext     <= '0;
      vcnt_ext     <= '0;
      HSYNC_ext    <= SYNC_ACTIVE;
      VSYNC_ext    <= SYNC_ACTIVE;
      DE_ext       <= 1'b0;
      lock_pending <= 1'b0;
    end else begin
      hcnt_ext     <= h_nxt_c;
      vcnt_ext     <= v_nxt_c;
      HSYNC_ext    <= (CMP_W'(h_nxt_c) < CMP_W'(H_SYNCLEN)) ? SYNC_ACTIVE : SYNC_IDLE;
      VSYNC_ext    <= (CMP_W'(v_nxt_c) < CMP_W'(V_SYNCLEN)) ? SYNC_ACTIVE : SYNC_IDLE;
      DE_ext       <= in_window(CMP_W'(h_nxt_c), H_AVS, H_ACTIVE) &&
                      in_window(CMP_W'(v_nxt_c), V_AVS, V_ACTIVE);
      lock_pending <= lock_now_c && !line_end_c;
    end
  end

  // Horizontal: source pixel index holds at the last pixel
  scale_ctr #(
    .SCALE    (H_SCALE),
    .SUB_W    (SCTR_W),
    .MAIN_W   (HLBUF_W),
    .MAIN_MAX (CPS2_H_ACTIVE - 1),
    .WRAP     (1'b0)
  ) u_hscale (
    .clk     (PCLK_ext),
    .reset   (reset),
    .clear   (h_clear_c),
    .advance (1'b1),
    .sub     (hctr_ext),
    .main    (hcnt_ext_lbuf)
  );

  // Vertical: line-buffer slot wraps around the ring, steps once per line
  scale_ctr #(
    .SCALE    (V_SCALE),
    .SUB_W    (SCTR_W),
    .MAIN_W   (VLBUF_W),
    .MAIN_MAX (LBUF_SLOTS - 1),
    .WRAP     (1'b1)
  ) u_vscale (
    .clk     (PCLK_ext),
    .reset   (reset),
    .clear   (v_clear_c),
    .advance (line_end_c),
    .sub     (vctr_ext),
    .main    (vcnt_ext_lbuf)
  );

endmodule

// File: tb/tb_ext_timing_gen.sv
// Directed bench for ext_timing_gen using a compact timing mode so that the
// image window, slot wrap, frame lock and frame wrap fit in a short run.
module tb_ext_timing_gen;

  localparam int TB_H_TOTAL      = 782;
  localparam int TB_H_SYNCLEN    = 4;
  localparam int TB_H_BACKPORCH  = 4;
  localparam int TB_H_ACTIVE     = 772;
  localparam int TB_V_TOTAL      = 455;
  localparam int TB_V_SYNCLEN    = 2;
  localparam int TB_V_BACKPORCH  = 1;
  localparam int TB_V_ACTIVE     = 450;
  localparam int TB_H_SCALE      = 2;
  localparam int TB_V_SCALE      = 2;
  localparam int TB_H_IMG_OFFSET = 2;
  localparam int TB_V_IMG_OFFSET = 1;
  localparam int TB_V_LOCK_LINE  = 449;
  localparam int GOTO_LIMIT      = TB_H_TOTAL * TB_V_TOTAL + 16;

  logic        clk;
  logic        reset;
  logic        lock_en;
  logic        frame_sync;
  logic [10:0] hcnt_ext;
  logic [10:0] vcnt_ext;
  logic [8:0]  hcnt_ext_lbuf;
  logic [5:0]  vcnt_ext_lbuf;
  logic [2:0]  hctr_ext;
  logic [2:0]  vctr_ext;
  logic        hsync;
  logic        vsync;
  logic        de;

  ext_timing_gen #(
    .H_TOTAL      (TB_H_TOTAL),
    .H_SYNCLEN    (TB_H_SYNCLEN),
    .H_BACKPORCH  (TB_H_BACKPORCH),
    .H_ACTIVE     (TB_H_ACTIVE),
    .V_TOTAL      (TB_V_TOTAL),
    .V_SYNCLEN    (TB_V_SYNCLEN),
    .V_BACKPORCH  (TB_V_BACKPORCH),
    .V_ACTIVE     (TB_V_ACTIVE),
    .H_SCALE      (TB_H_SCALE),
    .V_SCALE      (TB_V_SCALE),
    .H_IMG_OFFSET (TB_H_IMG_OFFSET),
    .V_IMG_OFFSET (TB_V_IMG_OFFSET),
    .V_LOCK_LINE  (TB_V_LOCK_LINE)
  ) dut (
    .PCLK_ext      (clk),
    .reset         (reset),
    .lock_en       (lock_en),
    .frame_sync    (frame_sync),
    .hcnt_ext      (hcnt_ext),
    .vcnt_ext      (vcnt_ext),
    .hcnt_ext_lbuf (hcnt_ext_lbuf),
    .vcnt_ext_lbuf (vcnt_ext_lbuf),
    .hctr_ext      (hctr_ext),
    .vctr_ext      (vctr_ext),
    .HSYNC_ext     (hsync),
    .VSYNC_ext     (vsync),
    .DE_ext        (de)
  );

  // Expected outputs at a given (vcnt, hcnt)
  typedef struct packed {
    int v; int h; int hs; int vs; int de; int hc; int hl; int vc; int vl;
  } vec_t;

  vec_t seg1[$];
  vec_t seg2[$];
  vec_t post[$];

  int checks   = 0;
  int failures = 0;
  int mh = 0;
  int mv = 0;
  bit m_pend = 1'b0;
  int de_acc = 0;
  int hsl_acc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #30_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (v=%0d h=%0d)", mv, mh);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int v, input int h, input int hs, input int vs,
                              input int de_e, input int hc, input int hl,
                              input int vc, input int vl);
    vec_t t;
    t.v = v; t.h = h; t.hs = hs; t.vs = vs; t.de = de_e;
    t.hc = hc; t.hl = hl; t.vc = vc; t.vl = vl;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (at v=%0d h=%0d)", name, act, exp_v, mv, mh);
    end
  endtask

  // One clock; position model follows the inputs sampled at this edge
  task automatic tick();
    bit pend_eff;
    bit wrap;
    bit rst;
    pend_eff = lock_en && (m_pend || frame_sync);
    wrap     = (mh == TB_H_TOTAL - 1);
    rst      = reset;
    @(posedge clk);
    #1;
    if (rst) begin
      mh = 0; mv = 0; m_pend = 1'b0;
    end else if (wrap) begin
      mh = 0;
      mv = pend_eff ? TB_V_LOCK_LINE : ((mv == TB_V_TOTAL - 1) ? 0 : mv + 1);
      m_pend = 1'b0;
    end else begin
      mh = mh + 1;
      m_pend = pend_eff;
    end
    de_acc  += int'(de);
    hsl_acc += int'(!hsync);
  endtask

  task automatic goto(input int v, input int h);
    int n;
    n = 0;
    while (!(mv == v && mh == h) && n < GOTO_LIMIT) begin
      tick();
      n++;
    end
    if (mv != v || mh != h) begin
      checks++;
      failures++;
      $display("FAIL goto: position v=%0d h=%0d not reached, target v=%0d h=%0d", mv, mh, v, h);
    end
    chk("hcnt", int'(hcnt_ext), h);
    chk("vcnt", int'(vcnt_ext), v);
  endtask

  task automatic run_vec(input vec_t t);
    goto(t.v, t.h);
    chk("hsync", int'(hsync), t.hs);
    chk("vsync", int'(vsync), t.vs);
    chk("de", int'(de), t.de);
    chk("hctr", int'(hctr_ext), t.hc);
    chk("hlbuf", int'(hcnt_ext_lbuf), t.hl);
    chk("vctr", int'(vctr_ext), t.vc);
    chk("vlbuf", int'(vcnt_ext_lbuf), t.vl);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hcnt"}, int'(hcnt_ext), 0);
    chk({tag, "_vcnt"}, int'(vcnt_ext), 0);
    chk({tag, "_hlbuf"}, int'(hcnt_ext_lbuf), 0);
    chk({tag, "_vlbuf"}, int'(vcnt_ext_lbuf), 0);
    chk({tag, "_hctr"}, int'(hctr_ext), 0);
    chk({tag, "_vctr"}, int'(vctr_ext), 0);
    chk({tag, "_hsync"}, int'(hsync), 0);
    chk({tag, "_vsync"}, int'(vsync), 0);
    chk({tag, "_de"}, int'(de), 0);
  endtask

  initial begin
    reset = 1'b1; lock_en = 1'b0; frame_sync = 1'b0;

    //                v    h  hs vs de hc   hl vc vl
    seg1.push_back(mk(  0,   3, 0, 0, 0, 0,   0, 0, 0));
    seg1.push_back(mk(  0,   4, 1, 0, 0, 0,   0, 0, 0));
    seg1.push_back(mk(  1, 781, 1, 0, 0, 0,   0, 0, 0));
    seg1.push_back(mk(  2,   0, 0, 1, 0, 0,   0, 0, 0));
    seg1.push_back(mk(  2,   8, 1, 1, 0, 0,   0, 0, 0));
    seg1.push_back(mk(  3,   7, 1, 1, 0, 0,   0, 0, 0));
    seg1.push_back(mk(  3,   8, 1, 1, 1, 0,   0, 0, 0));
    seg1.push_back(mk(  3, 779, 1, 1, 1, 0,   0, 0, 0));
    seg1.push_back(mk(  3, 780, 1, 1, 0, 0,   0, 0, 0));
    seg1.push_back(mk(  4,   9, 1, 1, 1, 0,   0, 0, 0));
    seg1.push_back(mk(  4,  10, 1, 1, 1, 0,   0, 0, 0));
    seg1.push_back(mk(  4,  11, 1, 1, 1, 1,   0, 0, 0));
    seg1.push_back(mk(  4,  12, 1, 1, 1, 0,   1, 0, 0));
    seg1.push_back(mk(  4, 777, 1, 1, 1, 1, 383, 0, 0));
    seg1.push_back(mk(  4, 778, 1, 1, 1, 0,   0, 0, 0));
    seg1.push_back(mk(  5,  10, 1, 1, 1, 0,   0, 1, 0));
    seg1.push_back(mk(  6, 400, 1, 1, 1, 0, 195, 0, 1));
    seg1.push_back(mk(  7,   3, 0, 1, 0, 0,   0, 1, 1));
    seg1.push_back(mk( 83, 501, 1, 1, 1, 1, 245, 1, 39));
    seg1.push_back(mk( 84,   0, 0, 1, 0, 0,   0, 0, 0));
    seg1.push_back(mk( 85, 100, 1, 1, 1, 0,  45, 1, 0));
    seg1.push_back(mk( 86,  10, 1, 1, 1, 0,   0, 0, 1));

    seg2.push_back(mk(452,  10, 1, 1, 1, 0,   0, 0, 0));
    seg2.push_back(mk(452, 779, 1, 1, 1, 0,   0, 0, 0));
    seg2.push_back(mk(453,  10, 1, 1, 0, 0,   0, 0, 0));
    seg2.push_back(mk(454, 781, 1, 1, 0, 0,   0, 0, 0));
    seg2.push_back(mk(  0,   0, 0, 0, 0, 0,   0, 0, 0));

    post.push_back(mk(  0,   4, 1, 0, 0, 0,   0, 0, 0));
    post.push_back(mk(  2,   0, 0, 1, 0, 0,   0, 0, 0));

    repeat (3) tick();
    check_reset("reset");
    reset = 1'b0;

    foreach (seg1[i]) run_vec(seg1[i]);

    // Full-line DE and HSYNC-low counts
    goto(87, 0);
    de_acc = 0; hsl_acc = 0;
    repeat (TB_H_TOTAL) tick();
    chk("de_per_line", de_acc, 772);
    chk("hsync_low_per_line", hsl_acc, 4);

    // Pulse with lock disabled is ignored
    goto(88, 500);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    goto(89, 0);

    // Dropping lock_en discards a pending lock
    lock_en = 1'b1;
    goto(89, 100);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    goto(89, 200);
    lock_en = 1'b0; tick(); lock_en = 1'b1;
    goto(90, 0);

    // Lock mid-line; second pulse on the same line is absorbed
    goto(90, 500);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    goto(90, 600);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    goto(449, 0);
    goto(450, 0);

    foreach (seg2[i]) run_vec(seg2[i]);

    // Pulse coincident with the line wrap applies at that wrap
    goto(1, 781);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    chk("lock_wrap_vcnt", int'(vcnt_ext), 449);
    chk("lock_wrap_hcnt", int'(hcnt_ext), 0);
    chk("lock_wrap_vsync", int'(vsync), 1);

    // Single-cycle reset mid-frame
    goto(449, 300);
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset("midreset");
    foreach (post[i]) run_vec(post[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
